// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bounded bursts and rotating ownership so no producer starves.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_wdata
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e            state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]     owner_q, owner_d, last_q, last_d, win;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              win_vld, rel;

    // Scan from last_q+1 downwards in priority; later hits overwrite, so the nearest one wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % NUM_REQ]) begin
                win     = OW'((int'(last_q) + k) % NUM_REQ);
                win_vld = 1'b1;
            end
        end
    end

    assign busy       = state_q == GRANT;
    assign gnt        = gnt_q;
    assign owner      = owner_q;
    assign fifo_wr    = busy & req[owner_q] & ~fifo_full;
    assign ack        = gnt_q & {NUM_REQ{fifo_wr}};
    assign fifo_wdata = busy ? req_data[owner_q*DATA_W +: DATA_W] : '0;
    assign rel        = busy & (~req[owner_q] | (fifo_wr & (cnt_q == CW'(MAX_BURST - 1))));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (!busy || rel) begin
            state_d = win_vld ? GRANT : IDLE;
            gnt_d   = win_vld ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
            owner_d = win_vld ? win : owner_q;
            last_d  = win_vld ? win : last_q;
            cnt_d   = '0;
        end else if (fifo_wr) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench; each requester i presents word i*0x100 + (n+1)*0x10
// for its n-th word and requests while fewer than lim[i] words have been acked.
module tb_fifo_wr_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_full = 1'b0;
    logic         clr = 1'b1;
    logic [3:0]   req, gnt, ack;
    logic [127:0] req_data;
    logic [1:0]   owner;
    logic         busy, fifo_wr;
    logic [31:0]  fifo_wdata;
    int           idx[4];
    int           lim[4];
    int           errs = 0;
    int           checks = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
        .owner(owner), .busy(busy), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_wdata(fifo_wdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i]               = idx[i] < lim[i];
            req_data[i*32 +: 32] = 32'(i * 256 + (idx[i] + 1) * 16);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) idx[i] <= clr ? 0 : (ack[i] ? idx[i] + 1 : idx[i]);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) lim[i] = 0;
        repeat (2) cyc();
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b1;
        for (int i = 0; i < 4; i++) lim[i] = 0;
        repeat (2) cyc();
        checks++; if (gnt !== 4'b0) begin errs++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (ack !== 4'b0) begin errs++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (owner !== 2'd0) begin errs++; $display("FAIL reset_owner: got %0d want 0", owner); end
        checks++; if (fifo_wr !== 1'b0) begin errs++; $display("FAIL reset_wr: got %b want 0", fifo_wr); end
        checks++; if (fifo_wdata !== 32'h0) begin errs++; $display("FAIL reset_wdata: got %h want 0", fifo_wdata); end
    endtask

    task automatic test_single_burst();
        do_reset();
        lim[0] = 6;
        #1;
        checks++; if (gnt !== 4'b0000) begin errs++; $display("FAIL single_latency: gnt got %b want 0000", gnt); end
        for (int n = 0; n < 4; n++) begin
            cyc();
            checks++;
            if ({fifo_wr, ack, gnt, fifo_wdata} !== {1'b1, 4'b0001, 4'b0001, 32'(16 * (n + 1))}) begin
                errs++;
                $display("FAIL single_write%0d: wr=%b ack=%b gnt=%b data=%h want wr=1 ack=0001 gnt=0001 data=%h",
                         n, fifo_wr, ack, gnt, fifo_wdata, 32'(16 * (n + 1)));
            end
        end
        cyc();
        checks++;
        if ({fifo_wr, gnt, fifo_wdata} !== {1'b1, 4'b0001, 32'h50}) begin
            errs++;
            $display("FAIL single_regrant: wr=%b gnt=%b data=%h want wr=1 gnt=0001 data=00000050", fifo_wr, gnt, fifo_wdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) lim[i] = 8;
        #1;
        for (int n = 0; n < 32; n++) begin
            cyc();
            exp = 4'b0001 << ((n / 4) % 4);
            checks++;
            if ({fifo_wr, ack, gnt} !== {1'b1, exp, exp}) begin
                errs++;
                $display("FAIL rr_write%0d: wr=%b ack=%b gnt=%b want wr=1 ack=%b gnt=%b", n, fifo_wr, ack, gnt, exp, exp);
            end
        end
        cyc();
        checks++; if (fifo_wr !== 1'b0) begin errs++; $display("FAIL rr_extra_write: got %b want 0", fifo_wr); end
        cyc();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_full_stall();
        do_reset();
        lim[2] = 8;
        lim[3] = 8;
        #1;
        for (int n = 0; n < 2; n++) begin
            cyc();
            checks++;
            if ({fifo_wr, ack, fifo_wdata} !== {1'b1, 4'b0100, 32'(512 + 16 * (n + 1))}) begin
                errs++;
                $display("FAIL stall_pre%0d: wr=%b ack=%b data=%h want wr=1 ack=0100 data=%h",
                         n, fifo_wr, ack, fifo_wdata, 32'(512 + 16 * (n + 1)));
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            fifo_full = 1'b1;
            #1;
            checks++;
            if ({fifo_wr, ack, gnt} !== {1'b0, 4'b0000, 4'b0100}) begin
                errs++;
                $display("FAIL stall_full%0d: wr=%b ack=%b gnt=%b want wr=0 ack=0000 gnt=0100", k, fifo_wr, ack, gnt);
            end
        end
        @(negedge clk);
        fifo_full = 1'b0;
        #1;
        for (int n = 2; n < 4; n++) begin
            checks++;
            if ({fifo_wr, ack, fifo_wdata} !== {1'b1, 4'b0100, 32'(512 + 16 * (n + 1))}) begin
                errs++;
                $display("FAIL stall_post%0d: wr=%b ack=%b data=%h want wr=1 ack=0100 data=%h",
                         n, fifo_wr, ack, fifo_wdata, 32'(512 + 16 * (n + 1)));
            end
            cyc();
        end
        checks++; if (gnt !== 4'b1000) begin errs++; $display("FAIL stall_release: gnt got %b want 1000", gnt); end
    endtask

    task automatic test_drop();
        do_reset();
        lim[1] = 1;
        lim[3] = 8;
        #1;
        cyc();
        checks++; if ({fifo_wr, ack} !== {1'b1, 4'b0010}) begin errs++; $display("FAIL drop_write: wr=%b ack=%b want wr=1 ack=0010", fifo_wr, ack); end
        cyc();
        checks++; if ({fifo_wr, gnt} !== {1'b0, 4'b0010}) begin errs++; $display("FAIL drop_cycle: wr=%b gnt=%b want wr=0 gnt=0010", fifo_wr, gnt); end
        cyc();
        checks++; if (gnt !== 4'b1000) begin errs++; $display("FAIL drop_handover: gnt got %b want 1000", gnt); end
        lim[0] = 1;
        #1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if ({fifo_wr, ack} !== {1'b1, 4'b1000}) begin
                errs++;
                $display("FAIL drop_next%0d: wr=%b ack=%b want wr=1 ack=1000", n, fifo_wr, ack);
            end
            cyc();
        end
        checks++; if (gnt !== 4'b0001) begin errs++; $display("FAIL drop_counter: gnt got %b want 0001", gnt); end
        checks++; if (idx[1] !== 1) begin errs++; $display("FAIL drop_acks1: got %0d want 1", idx[1]); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        lim[0] = 8;
        #1;
        repeat (3) cyc();
        checks++; if (fifo_wr !== 1'b1) begin errs++; $display("FAIL rstmid_third: wr got %b want 1", fifo_wr); end
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, ack, busy, fifo_wr, fifo_wdata} !== 42'd0) begin
            errs++;
            $display("FAIL rstmid_async: gnt=%b ack=%b busy=%b wr=%b data=%h want all 0", gnt, ack, busy, fifo_wr, fifo_wdata);
        end
        clr = 1'b1;
        lim[0] = 0;
        lim[1] = 8;
        lim[3] = 8;
        cyc();
        checks++; if (fifo_wr !== 1'b0) begin errs++; $display("FAIL rstmid_held: wr got %b want 0", fifo_wr); end
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errs++; $display("FAIL rstmid_latency: gnt got %b want 0000", gnt); end
        cyc();
        checks++; if (gnt !== 4'b0010) begin errs++; $display("FAIL rstmid_first: gnt got %b want 0010", gnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        lim[3] = 4;
        #1;
        cyc();
        checks++; if ({gnt, owner} !== {4'b1000, 2'd3}) begin errs++; $display("FAIL wrap_own3: gnt=%b owner=%0d want 1000/3", gnt, owner); end
        lim[0] = 4;
        #1;
        repeat (4) cyc();
        checks++; if ({gnt, owner} !== {4'b0001, 2'd0}) begin errs++; $display("FAIL wrap_to0: gnt=%b owner=%0d want 0001/0", gnt, owner); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) lim[i] = 0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_drop();
        test_reset_mid_burst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
